// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state codes,
// the default memory depth and the width of the per-word byte counter.
package imem_loader_pkg;

    // Default number of 32-bit words in the target instruction memory.
    localparam int DEPTH_DEFAULT = 128;

    // Four bytes per word, so a 2-bit counter wraps exactly once per word.
    localparam int BCNT_W = 2;

    // Loader FSM state codes.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_BYTES = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four serial bytes into one big-endian 32-bit word.
// The first byte of a word lands in [31:24], the fourth in [7:0].
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;

    // The word as it stands once the current byte is shifted in; valid
    // together with word_complete_o so the loader can register it directly.
    assign word_o          = {shift_q[23:0], byte_i};
    assign word_complete_o = push_i && !clr_i && (cnt_q == {BCNT_W{1'b1}});

    // Next-state logic for the byte counter and shift register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (push_i) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = word_o;
        end
    end

    // Counter and shift register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: receives a word count followed by big-endian
// instruction bytes and writes them to word-indexed instruction memory,
// stalling the processor for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [IW-1:0] index_q, index_d;

    logic          byte_ready_q, imem_we_q, cpu_hold_q, done_q, err_q;
    logic [AW-1:0] imem_addr_q;
    logic [31:0]   imem_wdata_q;

    logic          xfer, start_ok, last_word;
    logic          asm_clr, asm_push, word_complete;
    logic [31:0]   asm_word;

    // byte_ready is registered and tracks state, so a transfer is simply
    // valid while the registered ready is high.
    assign xfer      = byte_valid && byte_ready_q;
    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERR));
    assign last_word = ((32'(index_q) + 32'd1) == 32'(count_q));
    assign asm_push  = xfer && (state_q == ST_BYTES);
    assign asm_clr   = start_ok || (xfer && (state_q == ST_COUNT)) ||
                       (state_q == ST_WRITE);

    imem_word_assembler u_asm (
        .clk             (clk),
        .rst             (rst),
        .clr_i           (asm_clr),
        .push_i          (asm_push),
        .byte_i          (byte_in),
        .word_o          (asm_word),
        .word_complete_o (word_complete)
    );

    // FSM next state, word count capture and word index update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_COUNT;
                    index_d = '0;
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    count_d = byte_in;
                    if (byte_in == 8'd0)
                        state_d = ST_DONE;
                    else if (32'(byte_in) > DEPTH)
                        state_d = ST_ERR;
                    else
                        state_d = ST_BYTES;
                end
            end
            ST_BYTES: begin
                if (word_complete)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // The index stops on the last written word so it never
                // reaches DEPTH even when N == DEPTH.
                if (last_word) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BYTES;
                    index_d = index_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; outputs derive from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            byte_ready_q <= (state_d == ST_COUNT) || (state_d == ST_BYTES);
            imem_we_q    <= (state_d == ST_WRITE) && (state_q == ST_BYTES);
            cpu_hold_q   <= (state_d == ST_COUNT) || (state_d == ST_BYTES) ||
                            (state_d == ST_WRITE);
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
            // Address and data change only when a write is launched and
            // hold their last values otherwise.
            if (word_complete) begin
                imem_addr_q  <= AW'(index_q);
                imem_wdata_q <= asm_word;
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 128: number of 32-bit instruction words in the target instruction memory.
REQ-002 Parameter AW, default 32: width of the word address driven to instruction memory.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 start  input  1: one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-006 byte_in  input  8: serial program byte.
REQ-007 byte_valid  input  1: byte_in holds a valid byte.
REQ-008 byte_ready  output  1: loader accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 imem_we  output  1: one-cycle write strobe to instruction memory.
REQ-010 imem_addr  output  AW: word index being written; memory is word-indexed, not byte-addressed.
REQ-011 imem_wdata  output  32: instruction word being written.
REQ-012 cpu_hold  output  1: holds the processor stalled while a load is in progress.
REQ-013 done  output  1: last load completed successfully.
REQ-014 err  output  1: last load was rejected because the word count exceeded DEPTH.

Function
REQ-015 States SHALL be IDLE, COUNT, BYTES, WRITE, DONE and ERR.
REQ-016 IDLE/DONE/ERR + start SHALL go to COUNT, clear done/err, zero the word index, and assert cpu_hold from the next cycle.
REQ-017 start in COUNT, BYTES or WRITE SHALL be ignored.
REQ-018 COUNT: byte_ready=1; the first transferred byte is word count N (8-bit, unsigned).
REQ-019 N=0 SHALL go directly to DONE with no writes.
REQ-020 N>DEPTH SHALL go to ERR with no writes.
REQ-021 Otherwise the block SHALL go to BYTES with the byte counter set to 0.
REQ-022 BYTES: byte_ready=1; each transferred byte SHALL be shifted into a 32-bit assembly register, MSB first (big-endian): byte0->[31:24] ... byte3->[7:0].
REQ-023 byte_valid low SHALL stall the block indefinitely in its current state, with no timeout.
REQ-024 The transfer that completes the 4th byte (cycle k) SHALL move the block to WRITE, and imem_we=1 SHALL be driven in cycle k+1 with the current index and the assembled word; byte_ready=0 in WRITE.
REQ-025 WRITE SHALL increment the index; if index+1==N, go to DONE, else go to BYTES with the byte counter cleared.
REQ-026 imem_addr and imem_wdata SHALL be stable and meaningful only while imem_we=1; they hold their last values otherwise.
REQ-027 DONE/ERR: cpu_hold=0, byte_ready=0; done (resp. err) held high until the next accepted start or reset.
REQ-028 The word index SHALL never exceed DEPTH-1; a write to an address >= DEPTH is impossible by construction.
REQ-029 Bytes presented while byte_ready=0 SHALL be neither consumed nor stored.

Reset
REQ-030 rst SHALL take precedence over start and transfers in the same cycle.
REQ-031 rst SHALL force state=IDLE, with byte_ready, imem_we, cpu_hold, done and err all 0; imem_addr, imem_wdata, index, byte counter and assembly register all 0.
REQ-032 rst mid-load SHALL discard any partial word; words already written remain in memory.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the DEPTH default and the byte-count width constant.
REQ-034 One sub-module, imem_word_assembler, SHALL contain the byte counter and shift register; it reports word_complete and takes clr.
REQ-035 The FSM, index counter and output registers SHALL reside in imem_loader; all outputs are registered.

Verification
REQ-036 start, then bytes 02, AC C5 00 00, 8C 6A 00 03 -> imem_we pulses at addr 0 with data 0xACC50000 and at addr 1 with data 0x8C6A0003; then done=1, cpu_hold=0.
REQ-037 start, then N=0x00 -> DONE with no imem_we, done=1; count byte accepted in 1 cycle.
REQ-038 start, then N=0x81 (129) with DEPTH=128 -> err=1, done=0, no imem_we, byte_ready=0 afterwards.
REQ-039 N=1, bytes with byte_valid toggled 1/0 every cycle -> single write of the correct word at addr 0; no byte lost or duplicated.
REQ-040 N=3, rst asserted after 6 data bytes -> after reset all outputs are 0 and only addr 0 was written; a fresh load with N=1 then writes addr 0 correctly.
REQ-041 start pulsed in BYTES -> ignored; index and byte counter are unaffected.
